// File: rtl/memory_sequencer_pkg.sv
// Shared control-unit types for the memory block and its sequencer.
//   memory_op_e, address_reg_op_e, memory_bus_selector_e : memory control lines
//   mem_cmd_e       : commands accepted by memory_sequencer
//   mem_seq_state_e : memory_sequencer FSM states
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 8
`endif

package control;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } memory_op_e;

  typedef enum logic [2:0] {
    AR_NOP      = 3'd0,
    AR_INC      = 3'd1,
    AR_ABSOLUTE = 3'd2,
    AR_REL_ADD  = 3'd3,
    AR_REL_SUB  = 3'd4
  } address_reg_op_e;

  typedef enum logic {
    SEL_MAR = 1'b0,
    SEL_PC  = 1'b1
  } memory_bus_selector_e;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    LOAD    = 3'd1,
    STORE   = 3'd2,
    JUMP    = 3'd3,
    BR_FWD  = 3'd4,
    BR_BACK = 3'd5
  } mem_cmd_e;

  typedef enum logic [3:0] {
    IDLE, F_LO_A, F_LO_C, F_HI_A, F_HI_C, F_INC,
    SET_MAR, L_A, L_C, S_WR, PC_OP, ERR
  } mem_seq_state_e;

endpackage

// File: rtl/memory.sv
// Single-port memory block: MAR and PC address registers over a byte-cell
// array indexed by {address register, word selector}.
//   op / bus_selector / data_word_selector / address_reg_op : controls
//   data_in  : write data and address-register operand
//   data_out : read data, driven only while op == OP_READ
//   mar, pc  : current address registers (observation)
// Address-register ops and writes commit at negedge; reads latch at posedge.
import control::*;

module memory #(
  parameter int AW = `ADDR_BUS_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  memory_op_e           op,
  input  memory_bus_selector_e bus_selector,
  input  logic                 data_word_selector,
  input  address_reg_op_e      address_reg_op,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic [AW-1:0]        mar,
  output logic [AW-1:0]        pc
);

  logic [7:0]    cells [0:(1<<(AW+1))-1];
  logic [7:0]    rd_q;
  logic [AW-1:0] cur, nxt, operand;

  assign cur     = (bus_selector == SEL_PC) ? pc : mar;
  assign operand = AW'(data_in);

  always_comb begin
    nxt = cur;
    case (address_reg_op)
      AR_INC:      nxt = cur + AW'(1);
      AR_ABSOLUTE: nxt = operand;
      AR_REL_ADD:  nxt = cur + operand;
      AR_REL_SUB:  nxt = cur - operand;
      default:     nxt = cur;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      mar <= '0;
      pc  <= '0;
    end else if (address_reg_op != AR_NOP) begin
      if (bus_selector == SEL_PC) pc <= nxt;
      else                        mar <= nxt;
    end
  end

  always_ff @(negedge clock) begin
    if (op == OP_WRITE) cells[{cur, data_word_selector}] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (op == OP_READ) rd_q <= cells[{cur, data_word_selector}];
  end

  assign data_out = (op == OP_READ) ? rd_q : 8'h00;

endmodule

// File: rtl/memory_sequencer.sv
// Command-driven sequencer for the memory block. Accepts one command per
// cmd_valid/cmd_ready handshake and expands it into per-cycle memory controls.
//   cmd_valid/cmd_ready/cmd/cmd_addr/cmd_wdata/cmd_word : command handshake
//   done, cmd_error       : completion pulses (registered, first IDLE cycle)
//   instr_lo/hi, load_data: last fetched / loaded bytes
//   mem_*                 : memory control lines and data
// Moore FSM: memory controls depend only on state and latched command fields.
import control::*;

module memory_sequencer #(
  parameter int ADDR_BUS_WIDTH = `ADDR_BUS_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  mem_cmd_e             cmd,
  input  logic [7:0]           cmd_addr,
  input  logic [7:0]           cmd_wdata,
  input  logic                 cmd_word,
  output logic                 done,
  output logic                 cmd_error,
  output logic [7:0]           instr_lo,
  output logic [7:0]           instr_hi,
  output logic [7:0]           load_data,
  output memory_op_e           mem_op,
  output memory_bus_selector_e mem_bus_selector,
  output logic                 mem_word_selector,
  output address_reg_op_e      mem_address_reg_op,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);

  // Operands are 8-bit; with a wider bus the upper PC/MAR bits are only
  // reachable through relative steps and increments.
  if (ADDR_BUS_WIDTH > 8) begin : g_wide_bus
  end

  mem_seq_state_e state, state_n;
  mem_cmd_e       cmd_q;
  logic [7:0]     addr_q, wdata_q;
  logic           word_q;
  logic           accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= FETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= 1'b0;
      done      <= 1'b0;
      cmd_error <= 1'b0;
      instr_lo  <= '0;
      instr_hi  <= '0;
      load_data <= '0;
    end else begin
      state     <= state_n;
      // every non-IDLE state that returns to IDLE is a command's last state
      done      <= (state != IDLE) && (state_n == IDLE);
      cmd_error <= (state == ERR);
      if (accept) begin
        cmd_q   <= cmd;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        word_q  <= cmd_word;
      end
      if (state == F_LO_C) instr_lo  <= mem_rdata;
      if (state == F_HI_C) instr_hi  <= mem_rdata;
      if (state == L_C)    load_data <= mem_rdata;
    end
  end

  always_comb begin
    state_n            = state;
    mem_op             = OP_NOP;
    mem_bus_selector   = SEL_MAR;
    mem_word_selector  = 1'b0;
    mem_address_reg_op = AR_NOP;
    mem_wdata          = 8'h00;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            FETCH:                 state_n = F_LO_A;
            LOAD, STORE:           state_n = SET_MAR;
            JUMP, BR_FWD, BR_BACK: state_n = PC_OP;
            default:               state_n = ERR;
          endcase
        end
      end
      // *_A lets the memory latch the cell, *_C samples it; same controls
      F_LO_A, F_LO_C: begin
        mem_op           = OP_READ;
        mem_bus_selector = SEL_PC;
        state_n          = (state == F_LO_A) ? F_LO_C : F_HI_A;
      end
      F_HI_A, F_HI_C: begin
        mem_op            = OP_READ;
        mem_bus_selector  = SEL_PC;
        mem_word_selector = 1'b1;
        state_n           = (state == F_HI_A) ? F_HI_C : F_INC;
      end
      F_INC: begin
        mem_bus_selector   = SEL_PC;
        mem_address_reg_op = AR_INC;
        state_n            = IDLE;
      end
      SET_MAR: begin
        mem_address_reg_op = AR_ABSOLUTE;
        mem_wdata          = addr_q;
        state_n            = (cmd_q == LOAD) ? L_A : S_WR;
      end
      L_A, L_C: begin
        mem_op            = OP_READ;
        mem_word_selector = word_q;
        state_n           = (state == L_A) ? L_C : IDLE;
      end
      S_WR: begin
        mem_op            = OP_WRITE;
        mem_word_selector = word_q;
        mem_wdata         = wdata_q;
        state_n           = IDLE;
      end
      PC_OP: begin
        mem_bus_selector = SEL_PC;
        mem_wdata        = addr_q;
        case (cmd_q)
          JUMP:    mem_address_reg_op = AR_ABSOLUTE;
          BR_FWD:  mem_address_reg_op = AR_REL_ADD;
          BR_BACK: mem_address_reg_op = AR_REL_SUB;
          default: mem_address_reg_op = AR_NOP;
        endcase
        state_n = IDLE;
      end
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
